// File: rtl/ras_ckpt.sv
`default_nettype none
// ============================================================================
//  Module   : ras_ckpt
//  Purpose  : Return-address stack with checkpoint/restore for misprediction
//             repair. Circular storage of 2**RAS_INDEX entries, push/pop
//             decoded from JAL/JALR link-register usage.
//  Config   : RAS_REPAIR_EN -- when defined, restore reinstates a checkpoint
//             {tos, count, top}; when undefined, restore clears the stack and
//             the checkpoint output is tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module ras_ckpt #(
   parameter int RAS_INDEX = 3,
   parameter int ADDR_W    = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          i_stall,
   input  logic                          i_is_jal,
   input  logic                          i_is_jalr,
   input  logic [4:0]                    i_rd,
   input  logic [4:0]                    i_rs1,
   input  logic [ADDR_W-1:0]             i_pcp4,
   input  logic                          i_restore,
   input  logic [2*RAS_INDEX+ADDR_W:0]   i_restore_ckpt,
   output logic [2*RAS_INDEX+ADDR_W:0]   o_ckpt,
   output logic [ADDR_W-1:0]             o_target_addr,
   output logic                          o_empty,
   output logic                          o_full
);

   localparam int                 DEPTH      = 2**RAS_INDEX;
   localparam logic [RAS_INDEX:0] c_DEPTH    = (RAS_INDEX+1)'(DEPTH);
   localparam logic [RAS_INDEX:0] c_CNT_ONE  = (RAS_INDEX+1)'(1);
   localparam logic [RAS_INDEX-1:0] c_TOS_ONE = RAS_INDEX'(1);

   // Architectural stack state
   logic [RAS_INDEX-1:0] r_tos;
   logic [RAS_INDEX:0]   r_count;
   logic [ADDR_W-1:0]    r_mem [DEPTH];

   // Decode and next-state helpers
   logic                 w_link_rd;
   logic                 w_link_rs1;
   logic                 w_active;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_swap;
   logic                 w_empty;
   logic [RAS_INDEX-1:0] w_tos_inc;
   logic [RAS_INDEX-1:0] w_tos_dec;
   logic [RAS_INDEX:0]   w_cnt_inc;
   logic [RAS_INDEX:0]   w_cnt_dec;

   // Storage write port
   logic                 w_we;
   logic [RAS_INDEX-1:0] w_waddr;
   logic [ADDR_W-1:0]    w_wdata;

`ifdef RAS_REPAIR_EN
   // Checkpoint fields, laid out as {tos, count, top}
   logic [RAS_INDEX-1:0] w_ck_tos;
   logic [RAS_INDEX:0]   w_ck_cnt;
   logic [RAS_INDEX:0]   w_ck_cnt_clamped;
   logic [ADDR_W-1:0]    w_ck_top;

   assign w_ck_tos = i_restore_ckpt[2*RAS_INDEX+ADDR_W -: RAS_INDEX];
   assign w_ck_cnt = i_restore_ckpt[ADDR_W +: RAS_INDEX+1];
   assign w_ck_top = i_restore_ckpt[ADDR_W-1:0];
   // A corrupt checkpoint can never claim more entries than physically exist
   assign w_ck_cnt_clamped = (w_ck_cnt > c_DEPTH) ? c_DEPTH : w_ck_cnt;
`else
   // Checkpoint contents are irrelevant when repair only clears the stack
   logic w_unused_ckpt;
   assign w_unused_ckpt = ^i_restore_ckpt;
`endif

   // Classify the executing instruction by its link-register usage
   always_comb begin
      w_link_rd  = (i_rd  == 5'd1) || (i_rd  == 5'd5);
      w_link_rs1 = (i_rs1 == 5'd1) || (i_rs1 == 5'd5);
      w_active   = (i_is_jal || i_is_jalr) && !i_stall;
      // Both-link with differing registers is a coroutine swap, not a push
      w_swap     = w_active && w_link_rd && w_link_rs1 && (i_rd != i_rs1);
      w_push     = w_active && w_link_rd && !w_swap;
      w_pop      = w_active && !w_link_rd && w_link_rs1;
      w_empty    = (r_count == '0);
      w_tos_inc  = r_tos + c_TOS_ONE;
      w_tos_dec  = r_tos - c_TOS_ONE;
      // Count saturates: a push on a full stack silently loses the oldest entry
      w_cnt_inc  = (r_count == c_DEPTH) ? c_DEPTH : (r_count + c_CNT_ONE);
      w_cnt_dec  = r_count - c_CNT_ONE;
   end

   // Select the single storage write for this cycle; restore wins over push/swap
   always_comb begin
      w_we    = 1'b0;
      w_waddr = r_tos;
      w_wdata = i_pcp4;
      if (i_restore) begin
`ifdef RAS_REPAIR_EN
         w_we    = 1'b1;
         w_waddr = w_ck_tos;
         w_wdata = w_ck_top;
`endif
      end else if (w_push) begin
         w_we    = 1'b1;
         w_waddr = w_tos_inc;
      end else if (w_swap) begin
         w_we    = 1'b1;
      end
   end

   // Pointer and occupancy update; restore ignores stall and overrides decode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tos   <= '0;
         r_count <= '0;
      end else if (i_restore) begin
`ifdef RAS_REPAIR_EN
         r_tos   <= w_ck_tos;
         r_count <= w_ck_cnt_clamped;
`else
         r_tos   <= '0;
         r_count <= '0;
`endif
      end else if (w_push) begin
         r_tos   <= w_tos_inc;
         r_count <= w_cnt_inc;
      end else if (w_pop && !w_empty) begin
         r_tos   <= w_tos_dec;
         r_count <= w_cnt_dec;
      end else if (w_swap && w_empty) begin
         // Swap replaces the top in place; on an empty stack it creates one entry
         r_count <= c_CNT_ONE;
      end
   end

   // Entry storage is not reset; occupancy alone defines validity
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_waddr] <= w_wdata;
      end
   end

   assign o_target_addr = r_mem[r_tos];
   assign o_empty       = w_empty;
   assign o_full        = (r_count == c_DEPTH);

`ifdef RAS_REPAIR_EN
   assign o_ckpt = {r_tos, r_count, r_mem[r_tos]};
`else
   assign o_ckpt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ras_ckpt.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ras_ckpt
//  Purpose  : Scoreboard bench for ras_ckpt. A driver issues directed and
//             random instructions, updating an array-based stack model and
//             queueing the expected visible state; a monitor compares after
//             each clock edge. Honours RAS_REPAIR_EN like the design.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ras_ckpt;

   localparam int RI    = 3;
   localparam int AW    = 32;
   localparam int DEPTH = 8;
   localparam int CKW   = 2*RI+1+AW;

   logic           clk;
   logic           rst_n;
   logic           i_stall;
   logic           i_is_jal;
   logic           i_is_jalr;
   logic [4:0]     i_rd;
   logic [4:0]     i_rs1;
   logic [AW-1:0]  i_pcp4;
   logic           i_restore;
   logic [CKW-1:0] i_restore_ckpt;
   logic [CKW-1:0] o_ckpt;
   logic [AW-1:0]  o_target_addr;
   logic           o_empty;
   logic           o_full;

   ras_ckpt #(.RAS_INDEX(RI), .ADDR_W(AW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_stall        (i_stall),
      .i_is_jal       (i_is_jal),
      .i_is_jalr      (i_is_jalr),
      .i_rd           (i_rd),
      .i_rs1          (i_rs1),
      .i_pcp4         (i_pcp4),
      .i_restore      (i_restore),
      .i_restore_ckpt (i_restore_ckpt),
      .o_ckpt         (o_ckpt),
      .o_target_addr  (o_target_addr),
      .o_empty        (o_empty),
      .o_full         (o_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic           empty;
      logic           full;
      logic           tv;
      logic [AW-1:0]  tgt;
      logic [CKW-1:0] ck;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference stack: a ring of return addresses plus a top index and depth
   int          m_tos;
   int          m_cnt;
   logic [31:0] m_stk [DEPTH];
   bit          m_known [DEPTH];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [CKW-1:0] model_ckpt();
      logic [RI-1:0] t;
      logic [RI:0]   c;
      t = m_tos[RI-1:0];
      c = m_cnt[RI:0];
      return {t, c, m_stk[m_tos]};
   endfunction

   function automatic exp_t model_exp();
      exp_t e;
      e.empty = (m_cnt == 0);
      e.full  = (m_cnt == DEPTH);
      e.tv    = m_known[m_tos];
      e.tgt   = m_stk[m_tos];
`ifdef RAS_REPAIR_EN
      e.ck    = model_ckpt();
`else
      e.ck    = '0;
`endif
      return e;
   endfunction

   task automatic model_reset();
      m_tos = 0;
      m_cnt = 0;
      for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
   endtask

   function automatic bit is_link(input logic [4:0] r);
      return (r == 5'd1) || (r == 5'd5);
   endfunction

   // Apply one instruction's effect to the reference stack
   task automatic model_apply(input logic jal, input logic jalr, input logic stall,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [31:0] pc, input logic rs,
                              input logic [CKW-1:0] ck);
      if (rs) begin
`ifdef RAS_REPAIR_EN
         m_tos = int'(ck[CKW-1 -: RI]);
         m_cnt = int'(ck[AW +: RI+1]);
         if (m_cnt > DEPTH) m_cnt = DEPTH;
         m_stk[m_tos]   = ck[AW-1:0];
         m_known[m_tos] = 1'b1;
`else
         m_tos = 0;
         m_cnt = 0;
`endif
      end else if ((jal || jalr) && !stall) begin
         if (is_link(rd) && is_link(rs1) && rd != rs1) begin
            m_stk[m_tos]   = pc;
            m_known[m_tos] = 1'b1;
            if (m_cnt == 0) m_cnt = 1;
         end else if (is_link(rd)) begin
            m_tos          = (m_tos + 1) % DEPTH;
            m_stk[m_tos]   = pc;
            m_known[m_tos] = 1'b1;
            if (m_cnt < DEPTH) m_cnt++;
         end else if (is_link(rs1) && m_cnt > 0) begin
            m_tos = (m_tos + DEPTH - 1) % DEPTH;
            m_cnt--;
         end
      end
   endtask

   // Drive one cycle of stimulus and queue the state expected after the edge
   task automatic step(input logic jal, input logic jalr, input logic stall,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [31:0] pc, input logic rs,
                       input logic [CKW-1:0] ck);
      @(negedge clk);
      i_is_jal       = jal;
      i_is_jalr      = jalr;
      i_stall        = stall;
      i_rd           = rd;
      i_rs1          = rs1;
      i_pcp4         = pc;
      i_restore      = rs;
      i_restore_ckpt = ck;
      model_apply(jal, jalr, stall, rd, rs1, pc, rs, ck);
      exp_q.push_back(model_exp());
   endtask

   task automatic push(input logic [31:0] pc);
      step(1'b1, 1'b0, 1'b0, 5'd1, 5'd0, pc, 1'b0, '0);
   endtask

   task automatic pop();
      step(1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 32'h0, 1'b0, '0);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, '0);
   endtask

   // Assert reset between edges and confirm it acts without a clock
   task automatic do_reset();
      @(posedge clk);
      #3;
      i_is_jal  = 1'b0;
      i_is_jalr = 1'b0;
      i_restore = 1'b0;
      rst_n     = 1'b0;
      #1;
      chk("async_rst_empty", 64'(o_empty), 64'd1);
      chk("async_rst_full", 64'(o_full), 64'd0);
`ifdef RAS_REPAIR_EN
      chk("async_rst_ckpt_tc", 64'(o_ckpt[CKW-1:AW]), 64'd0);
`endif
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [4:0] pick_reg();
      case ($urandom_range(0, 3))
         0:       return 5'd1;
         1:       return 5'd5;
         2:       return 5'd0;
         default: return 5'($urandom_range(0, 31));
      endcase
   endfunction

   // Monitor: after each edge, compare the visible state against the queue head
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("empty", 64'(o_empty), 64'(e.empty));
            chk("full", 64'(o_full), 64'(e.full));
            if (e.tv) chk("target", 64'(o_target_addr), 64'(e.tgt));
`ifdef RAS_REPAIR_EN
            if (e.tv) chk("ckpt", 64'(o_ckpt), 64'(e.ck));
            else      chk("ckpt_tos_cnt", 64'(o_ckpt[CKW-1:AW]), 64'(e.ck[CKW-1:AW]));
`else
            chk("ckpt_zero", 64'(o_ckpt), 64'd0);
`endif
         end
      end
   end

   initial begin
      logic [CKW-1:0] saved;
      rst_n          = 1'b1;
      i_stall        = 1'b0;
      i_is_jal       = 1'b0;
      i_is_jalr      = 1'b0;
      i_rd           = '0;
      i_rs1          = '0;
      i_pcp4         = '0;
      i_restore      = 1'b0;
      i_restore_ckpt = '0;
      for (int i = 0; i < DEPTH; i++) m_stk[i] = '0;
      model_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("reset_empty", 64'(o_empty), 64'd1);
      chk("reset_full", 64'(o_full), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Basic call/return
      push(32'h100);
      push(32'h200);
      pop();

      // Overflow through wrap-around, drain, and pop on empty
      do_reset();
      for (int i = 1; i <= 9; i++) push(32'(i * 16));
      for (int i = 0; i < 9; i++) pop();

      // Both-link swap on a populated and an empty stack
      do_reset();
      push(32'h100);
      push(32'h200);
      step(1'b0, 1'b1, 1'b0, 5'd1, 5'd5, 32'h300, 1'b0, '0);
      do_reset();
      step(1'b0, 1'b1, 1'b0, 5'd1, 5'd5, 32'h300, 1'b0, '0);
      // Same-register both-link is a plain push
      step(1'b1, 1'b0, 1'b0, 5'd5, 5'd5, 32'h340, 1'b0, '0);

      // Stall blocks decode but not restore
      step(1'b1, 1'b0, 1'b1, 5'd1, 5'd0, 32'h400, 1'b0, '0);
      step(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 32'h0, 1'b1, {3'd6, 4'd3, 32'h0000_0600});

      // Checkpoint repair with a competing push
      do_reset();
      push(32'h100);
      push(32'h200);
      saved = model_ckpt();
      push(32'h500);
      push(32'h600);
      push(32'h700);
      step(1'b1, 1'b0, 1'b0, 5'd1, 5'd0, 32'h800, 1'b1, saved);
      // Oversized checkpoint count saturates
      step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b1, {3'd2, 4'd13, 32'h0000_0abc});
      pop();

      // Asynchronous reset mid-operation, then first push lands in entry 1
      do_reset();
      for (int i = 0; i < 5; i++) push(32'h1000 + 32'(i));
      do_reset();
      push(32'h2000);
      idle();

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic [CKW-1:0] rck;
         logic           rs;
         rs  = ($urandom_range(0, 15) == 0);
         rck = {3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 32'($urandom)};
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0), pick_reg(), pick_reg(),
              {$urandom_range(0, 65535), 16'h0} | 32'($urandom_range(0, 65535)),
              rs, rck);
      end
      idle();

      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ras_ckpt.md
RAS_CKPT -- requirements
Module: ras_ckpt

Interface
REQ-001 Parameter RAS_INDEX, default 3, log2 of stack depth; DEPTH = 2**RAS_INDEX entries.
REQ-002 Parameter ADDR_W, default 32, return-address width.
REQ-003 clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 stall  input  1  high blocks all push/pop updates this cycle.
REQ-006 is_jal, is_jalr  input  1 each  the executing instruction is JAL or JALR.
REQ-007 rd, rs1  input  5 each  register fields of the executing instruction.
REQ-008 pcp4  input  ADDR_W  PC+4 of the executing instruction; the value pushed.
REQ-009 restore  input  1  misprediction repair request.
REQ-010 restore_ckpt  input  RAS_INDEX+RAS_INDEX+1+ADDR_W  checkpoint to reinstate: {tos, count, top}.
REQ-011 ckpt_out  output  same width as restore_ckpt  current {tos, count, top}, taken by the front end per prediction.
REQ-012 target_addr_out  output  ADDR_W  entry at tos; predicted return target.
REQ-013 empty  output  1  count == 0.
REQ-014 full  output  1  count == DEPTH.

Function
REQ-015 Storage: circular array of DEPTH entries, tos pointer of RAS_INDEX bits, count of RAS_INDEX+1 bits saturating at DEPTH.
REQ-016 link(x) is true when x == 1 or x == 5.
REQ-017 Decode applies only when (is_jal or is_jalr) and not stall. Otherwise no push and no pop.
REQ-018 Decode: !link(rd),!link(rs1) -> none; !link(rd),link(rs1) -> pop; link(rd),!link(rs1) -> push; both link and rd == rs1 -> push; both link and rd != rs1 -> pop-then-push.
REQ-019 Push: tos <= tos+1 mod DEPTH; entry[tos+1] <= pcp4; count <= min(count+1, DEPTH).
REQ-020 Push when full overwrites the oldest entry through wrap-around. count stays DEPTH.
REQ-021 Pop: tos <= tos-1 mod DEPTH; count <= count-1.
REQ-022 Pop when empty: no state change. target_addr_out is don't-care-stable (holds entry[tos]).
REQ-023 Pop-then-push: entry[tos] <= pcp4. tos and count do not change. This is legal when empty, and count then becomes 1.
REQ-024 Updates take effect at the next rising edge. target_addr_out, empty, full and ckpt_out are combinational from registered state, so they have 1-cycle visibility latency.
REQ-025 ckpt_out reflects pre-update state in the cycle the instruction is presented.
REQ-026 Restore has priority over push/pop and ignores stall.
REQ-027 With restore asserted, tos, count and entry[restore tos] <= restore_ckpt fields. Push and pop are dropped that cycle.
REQ-028 count in restore_ckpt greater than DEPTH is clamped to DEPTH.

Reset
REQ-029 On rst low, immediately and independent of clk: tos = 0, count = 0, empty = 1, full = 0.
REQ-030 Entries need not be reset. target_addr_out is undefined until the first push or restore.
REQ-031 Reset asserted mid-operation discards all entries. The first push after release writes entry[1].
REQ-032 Release is sampled synchronously: the first update occurs on the first clk edge with rst high.

Configuration
REQ-033 The macro RAS_REPAIR_EN selects the repair behaviour.
REQ-034 RAS_REPAIR_EN defined: restore behaves per REQ-026..028.
REQ-035 RAS_REPAIR_EN undefined: restore clears tos and count to 0, restore_ckpt is ignored, and ckpt_out is driven to 0. Port list is identical in both builds.

Verification
REQ-036 Push: RAS_INDEX=3, reset, JAL rd=1 pcp4=0x100 then JAL rd=1 pcp4=0x200 -> target 0x200, count 2; JALR rs1=1 rd=0 -> target 0x100, count 1.
REQ-037 Overflow: 9 pushes of 0x10..0x90 -> full=1, target 0x90. 8 pops -> targets 0x80..0x20 then empty=1. 9th pop -> no change.
REQ-038 Both link, rd=1 rs1=5, pcp4=0x300 on count=2 -> target 0x300, count 2, tos unchanged. Same on empty stack -> count 1.
REQ-039 Stall: JAL rd=1 with stall=1 -> state unchanged. restore with stall=1 applies (RAS_REPAIR_EN).
REQ-040 Repair (RAS_REPAIR_EN): capture ckpt_out at count 2/top 0x200, do 3 pushes, restore with that ckpt -> count 2, target 0x200. A simultaneous push is ignored. Without the macro, the same sequence gives empty=1.
REQ-041 Async reset: assert rst low between clk edges with count 5 -> empty=1 before the next edge.
